// File: rtl/seq_step_timer.sv
// Step timer for the pattern sequencer: syncs the divider tick,
// counts ticks per step and walks a looping step index.
module seq_step_timer #(
  parameter int TICKS_W     = 8,
  parameter int STEPS_W     = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic               CLK_50_MHz,
  input  logic               reset,
  input  logic               tick_in,
  input  logic               run,
  input  logic               restart,
  input  logic [TICKS_W-1:0] ticks_per_step,
  input  logic [STEPS_W-1:0] last_step,
  output logic [STEPS_W-1:0] step,
  output logic               step_strobe,
  output logic               tick_strobe,
  output logic               running
);

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    RUNNING
  } state_e;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   hist_q;
  logic                   tick_strobe_q;

  state_e                 state_q;
  logic [TICKS_W-1:0]     cnt_q;
  logic [STEPS_W-1:0]     step_q;
  logic                   step_strobe_q;

  logic [TICKS_W-1:0]     term_d;
  logic [STEPS_W-1:0]     step_d;

  always_ff @(posedge CLK_50_MHz) begin
    if (reset) begin
      sync_q        <= '0;
      hist_q        <= 1'b0;
      tick_strobe_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], tick_in};
      hist_q        <= sync_q[SYNC_STAGES-1];
      tick_strobe_q <= sync_q[SYNC_STAGES-1] & ~hist_q;
    end
  end

  // A ticks_per_step of 0 behaves like 1, so terminal count is 0.
  always_comb begin
    term_d = '0;
    if (ticks_per_step != '0)
      term_d = ticks_per_step - 1'b1;
  end

  // >= so that shrinking last_step mid-run wraps straight to 0.
  always_comb begin
    step_d = step_q + 1'b1;
    if (step_q >= last_step)
      step_d = '0;
  end

  always_ff @(posedge CLK_50_MHz) begin
    if (reset) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      step_q        <= '0;
      step_strobe_q <= 1'b0;
    end else begin
      step_strobe_q <= 1'b0;
      if (!run) begin
        state_q <= IDLE;
        cnt_q   <= '0;
      end else if (restart) begin
        step_q <= '0;
        cnt_q  <= '0;
        if (state_q != IDLE)
          state_q <= ARMED;
      end else begin
        unique case (state_q)
          IDLE: begin
            state_q <= ARMED;
          end
          ARMED: begin
            if (tick_strobe_q) begin
              state_q       <= RUNNING;
              step_q        <= '0;
              cnt_q         <= '0;
              step_strobe_q <= 1'b1;
            end
          end
          RUNNING: begin
            if (tick_strobe_q) begin
              if (cnt_q >= term_d) begin
                cnt_q         <= '0;
                step_q        <= step_d;
                step_strobe_q <= 1'b1;
              end else begin
                cnt_q <= cnt_q + 1'b1;
              end
            end
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign step        = step_q;
  assign step_strobe = step_strobe_q;
  assign tick_strobe = tick_strobe_q;
  assign running     = (state_q == RUNNING);

endmodule

// File: tb/tb_seq_step_timer.sv
// Bench for seq_step_timer: per-tick vector table plus a
// step-strobe scoreboard and hand-built restart/reset sequences.
module tb_seq_step_timer;
  localparam int TW = 8;
  localparam int SW = 4;
  localparam int SS = 2;

  logic          clk = 1'b0;
  logic          reset;
  logic          tick_in;
  logic          run;
  logic          restart;
  logic [TW-1:0] tps;
  logic [SW-1:0] last;
  logic [SW-1:0] step;
  logic          step_strobe;
  logic          tick_strobe;
  logic          running;

  always #5 clk = ~clk;

  seq_step_timer #(
    .TICKS_W(TW),
    .STEPS_W(SW),
    .SYNC_STAGES(SS)
  ) dut (
    .CLK_50_MHz(clk),
    .reset(reset),
    .tick_in(tick_in),
    .run(run),
    .restart(restart),
    .ticks_per_step(tps),
    .last_step(last),
    .step(step),
    .step_strobe(step_strobe),
    .tick_strobe(tick_strobe),
    .running(running)
  );

  typedef struct {
    logic          run;
    logic [TW-1:0] tps;
    logic [SW-1:0] last;
    logic          strb;
    logic [SW-1:0] stp;
    logic          rn;
  } vec_t;

  vec_t          vt[$];
  logic [SW-1:0] sb[$];
  int            errors = 0;
  int            checks = 0;
  int            ticks_driven = 0;
  int            ticks_seen = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // One clock, sampled on the falling edge; pops the scoreboard
  // on every step strobe.
  task automatic cyc();
    logic [SW-1:0] e;
    @(negedge clk);
    if (tick_strobe === 1'b1) ticks_seen++;
    if (step_strobe !== 1'b0) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe: got step_strobe=%b step=%0d expected no strobe",
                 step_strobe, step);
      end else begin
        e = sb.pop_front();
        chk("strobe_step", {28'd0, step}, {28'd0, e});
      end
    end
  endtask

  task automatic tick(input logic strb, input logic [SW-1:0] stp);
    if (strb) sb.push_back(stp);
    ticks_driven++;
    tick_in = 1'b1;
    repeat (3) cyc();
    tick_in = 1'b0;
    repeat (3) cyc();
    chk("missing_strobe", sb.size(), 0);
    sb.delete();
    chk("tick_count", ticks_seen, ticks_driven);
  endtask

  function automatic void add(input logic r, input logic [TW-1:0] t,
                              input logic [SW-1:0] l, input logic s,
                              input logic [SW-1:0] p, input logic n);
    vt.push_back('{run: r, tps: t, last: l, strb: s, stp: p, rn: n});
  endfunction

  task automatic apply(input int lo, input int hi);
    for (int i = lo; i < hi; i++) begin
      run     = vt[i].run;
      tps     = vt[i].tps;
      last    = vt[i].last;
      restart = 1'b0;
      tick(vt[i].strb, vt[i].stp);
      chk($sformatf("v%0d_step", i), {28'd0, step}, {28'd0, vt[i].stp});
      chk($sformatf("v%0d_running", i), {31'd0, running}, {31'd0, vt[i].rn});
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int lat;
    int found;
    reset   = 1'b1;
    tick_in = 1'b0;
    run     = 1'b0;
    restart = 1'b0;
    tps     = 8'd4;
    last    = 4'd3;

    // Idle ticks, then the 4-ticks-per-step run over 4 steps.
    add(0, 4, 3, 0, 0, 0);
    add(0, 4, 3, 0, 0, 0);
    for (int i = 0; i < 20; i++)
      add(1, 4, 3, (i % 4) == 0, SW'((i / 4) % 4), 1);
    // Stop, then ticks_per_step=0 over 3 steps.
    add(0, 0, 2, 0, 0, 0);
    for (int i = 0; i < 6; i++)
      add(1, 0, 2, 1, SW'(i % 3), 1);
    // Walk to step 6, then cut last_step to 3.
    add(1, 1, 7, 1, 3, 1);
    add(1, 1, 7, 1, 4, 1);
    add(1, 1, 7, 1, 5, 1);
    add(1, 1, 7, 1, 6, 1);
    add(1, 1, 3, 1, 0, 1);
    add(1, 1, 3, 1, 1, 1);
    // Lower ticks_per_step below the running count.
    add(1, 3, 3, 0, 1, 1);
    add(1, 3, 3, 0, 1, 1);
    add(1, 1, 3, 1, 2, 1);
    add(1, 1, 7, 1, 3, 1);
    add(1, 1, 7, 1, 4, 1);
    add(1, 1, 7, 1, 5, 1);
    k = vt.size();
    // After restart: advance, stop at 2, resume from 0.
    add(1, 1, 7, 1, 1, 1);
    add(1, 1, 7, 1, 2, 1);
    add(0, 1, 7, 0, 2, 0);
    add(1, 1, 7, 1, 0, 1);
    add(1, 1, 7, 1, 1, 1);

    repeat (3) cyc();
    reset = 1'b0;
    chk("rst_step", {28'd0, step}, 32'd0);
    chk("rst_step_strobe", {31'd0, step_strobe}, 32'd0);
    chk("rst_tick_strobe", {31'd0, tick_strobe}, 32'd0);
    chk("rst_running", {31'd0, running}, 32'd0);

    ticks_driven++;
    tick_in = 1'b1;
    lat = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (tick_strobe === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk("tick_latency", lat, SS + 1);
    tick_in = 1'b0;
    repeat (4) cyc();
    chk("latency_tick_count", ticks_seen, ticks_driven);

    apply(0, k);

    // Restart on the same cycle the tick strobe is seen.
    ticks_driven++;
    tick_in = 1'b1;
    found = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (tick_strobe === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("restart_tick_seen", found, 1);
    restart = 1'b1;
    cyc();
    restart = 1'b0;
    chk("restart_step", {28'd0, step}, 32'd0);
    chk("restart_no_strobe", {31'd0, step_strobe}, 32'd0);
    chk("restart_armed", {31'd0, running}, 32'd0);
    tick_in = 1'b0;
    repeat (3) cyc();
    tick(1'b1, 4'd0);
    chk("restrike_step", {28'd0, step}, 32'd0);
    chk("restrike_running", {31'd0, running}, 32'd1);

    apply(k, vt.size());

    // Reset while running, with tick_in held high across release.
    chk("pre_reset_step", {28'd0, step}, 32'd1);
    reset   = 1'b1;
    run     = 1'b0;
    tick_in = 1'b1;
    cyc();
    chk("mid_rst_step", {28'd0, step}, 32'd0);
    chk("mid_rst_step_strobe", {31'd0, step_strobe}, 32'd0);
    chk("mid_rst_tick_strobe", {31'd0, tick_strobe}, 32'd0);
    chk("mid_rst_running", {31'd0, running}, 32'd0);
    cyc();
    reset = 1'b0;
    ticks_driven++;
    found = 0;
    for (int n = 1; n <= 8; n++) begin
      cyc();
      if (tick_strobe === 1'b1) begin
        found = 1;
        break;
      end
    end
    chk("release_tick_seen", found, 1);
    tick_in = 1'b0;
    repeat (4) cyc();
    chk("release_tick_count", ticks_seen, ticks_driven);
    chk("release_step", {28'd0, step}, 32'd0);
    chk("release_running", {31'd0, running}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
